// File: rtl/mips_pkg.sv
// Shared encodings for the pipelined MIPS core: writeback source select,
// load types and the hard-wired zero register index.
package mips_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_LINK = 2'b10
   } wb_sel_e;

   typedef enum logic [2:0] {
      LD_W  = 3'b000,
      LD_H  = 3'b001,
      LD_HU = 3'b010,
      LD_B  = 3'b011,
      LD_BU = 3'b100
   } load_type_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment: picks the byte/halfword lane addressed by
// byte_off out of a 32-bit memory word and sign- or zero-extends it.
module load_align
   import mips_pkg::*;
(
   input  logic [31:0] mem_data,
   input  logic [2:0]  load_type,
   input  logic [1:0]  byte_off,
   output logic [31:0] aligned
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Byte lane 0 is the most significant byte of the word.
   always_comb begin
      case (byte_off)
         2'd0:    byte_lane = mem_data[31:24];
         2'd1:    byte_lane = mem_data[23:16];
         2'd2:    byte_lane = mem_data[15:8];
         default: byte_lane = mem_data[7:0];
      endcase
      half_lane = byte_off[1] ? mem_data[15:0] : mem_data[31:16];
   end

   // NOTE: every path through the case assigns 'aligned' and a default arm
   // covers the unused codes, so this stays combinational without latches.
   always_comb begin
      case (load_type)
         LD_H:    aligned = {{16{half_lane[15]}}, half_lane};
         LD_HU:   aligned = {16'h0000, half_lane};
         LD_B:    aligned = {{24{byte_lane[7]}}, byte_lane};
         LD_BU:   aligned = {24'h000000, byte_lane};
         default: aligned = mem_data;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: selects the register-file
// write value and bypasses it into the decode read ports.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic                  in_reg_write,
   input  logic [1:0]            in_wb_sel,
   input  logic [2:0]            in_load_type,
   input  logic [1:0]            in_byte_off,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_mem_data,
   input  logic [DATA_W-1:0]     in_link_pc,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [DATA_W-1:0]     id_rd1_raw,
   input  logic [DATA_W-1:0]     id_rd2_raw,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wr_reg,
   output logic [DATA_W-1:0]     rf_wr_data,
   output logic [DATA_W-1:0]     id_rd1,
   output logic [DATA_W-1:0]     id_rd2,
   output logic                  wb_valid
);

   logic                  valid_q,      valid_d;
   logic                  reg_write_q,  reg_write_d;
   logic [1:0]            wb_sel_q,     wb_sel_d;
   logic [2:0]            load_type_q,  load_type_d;
   logic [1:0]            byte_off_q,   byte_off_d;
   logic [REG_ADDR_W-1:0] dest_q,       dest_d;
   logic [DATA_W-1:0]     alu_result_q, alu_result_d;
   logic [DATA_W-1:0]     mem_data_q,   mem_data_d;
   logic [DATA_W-1:0]     link_pc_q,    link_pc_d;

   logic [31:0]           load_data;

   // Flush only kills valid; the payload fields are don't-care in a bubble.
   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      wb_sel_d     = wb_sel_q;
      load_type_d  = load_type_q;
      byte_off_d   = byte_off_q;
      dest_d       = dest_q;
      alu_result_d = alu_result_q;
      mem_data_d   = mem_data_q;
      link_pc_d    = link_pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d      = in_valid;
         reg_write_d  = in_reg_write;
         wb_sel_d     = in_wb_sel;
         load_type_d  = in_load_type;
         byte_off_d   = in_byte_off;
         dest_d       = in_dest;
         alu_result_d = in_alu_result;
         mem_data_d   = in_mem_data;
         link_pc_d    = in_link_pc;
      end
   end

   // NOTE: non-blocking assignments so every stage register samples the
   // pre-edge value of its next-state signal, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         wb_sel_q     <= '0;
         load_type_q  <= '0;
         byte_off_q   <= '0;
         dest_q       <= '0;
         alu_result_q <= '0;
         mem_data_q   <= '0;
         link_pc_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         wb_sel_q     <= wb_sel_d;
         load_type_q  <= load_type_d;
         byte_off_q   <= byte_off_d;
         dest_q       <= dest_d;
         alu_result_q <= alu_result_d;
         mem_data_q   <= mem_data_d;
         link_pc_q    <= link_pc_d;
      end
   end

   load_align u_load_align (
      .mem_data  (mem_data_q[31:0]),
      .load_type (load_type_q),
      .byte_off  (byte_off_q),
      .aligned   (load_data)
   );

   always_comb begin
      case (wb_sel_q)
         WB_LOAD: rf_wr_data = DATA_W'(load_data);
         WB_LINK: rf_wr_data = link_pc_q;
         default: rf_wr_data = alu_result_q;
      endcase
   end

   assign rf_we     = valid_q && reg_write_q && (dest_q != REG_ADDR_W'(REG_ZERO));
   assign rf_wr_reg = dest_q;
   assign wb_valid  = valid_q;

   // The register file reads combinationally, so a same-cycle write must be forwarded.
   assign id_rd1 = (rf_we && (rf_wr_reg == id_rs)) ? rf_wr_data : id_rd1_raw;
   assign id_rd2 = (rf_we && (rf_wr_reg == id_rt)) ? rf_wr_data : id_rd2_raw;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven vectors through a
// scoreboard queue, plus reset, stall and flush sequences.
module tb_mem_wb_stage;

   typedef struct {
      logic        valid;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic [2:0]  lt;
      logic [1:0]  off;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] link;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] raw1;
      logic [31:0] raw2;
   } stim_t;

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] data;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        valid;
      logic        chk_rf;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   localparam int NV = 17;
   localparam logic [31:0] MD = 32'h80F1A27F;
   localparam logic [31:0] LP = 32'h00400008;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        in_valid, in_reg_write;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_load_type;
   logic [1:0]  in_byte_off;
   logic [4:0]  in_dest;
   logic [31:0] in_alu_result, in_mem_data, in_link_pc;
   logic [4:0]  id_rs, id_rt;
   logic [31:0] id_rd1_raw, id_rd2_raw;
   logic        rf_we, wb_valid;
   logic [4:0]  rf_wr_reg;
   logic [31:0] rf_wr_data, id_rd1, id_rd2;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   vec_t vecs[NV];

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_reg_write  (in_reg_write),
      .in_wb_sel     (in_wb_sel),
      .in_load_type  (in_load_type),
      .in_byte_off   (in_byte_off),
      .in_dest       (in_dest),
      .in_alu_result (in_alu_result),
      .in_mem_data   (in_mem_data),
      .in_link_pc    (in_link_pc),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd1_raw    (id_rd1_raw),
      .id_rd2_raw    (id_rd2_raw),
      .rf_we         (rf_we),
      .rf_wr_reg     (rf_wr_reg),
      .rf_wr_data    (rf_wr_data),
      .id_rd1        (id_rd1),
      .id_rd2        (id_rd2),
      .wb_valid      (wb_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input stim_t s, input logic st, input logic fl, input logic r);
      rst           = r;
      stall         = st;
      flush         = fl;
      in_valid      = s.valid;
      in_reg_write  = s.reg_write;
      in_wb_sel     = s.wb_sel;
      in_load_type  = s.lt;
      in_byte_off   = s.off;
      in_dest       = s.dest;
      in_alu_result = s.alu;
      in_mem_data   = s.mem;
      in_link_pc    = s.link;
      id_rs         = s.rs;
      id_rt         = s.rt;
      id_rd1_raw    = s.raw1;
      id_rd2_raw    = s.raw2;
   endtask

   // Drive one cycle, queue its expectation, then compare after the edge.
   task automatic cycle(input string tag, input stim_t s, input exp_t e,
                        input logic st, input logic fl, input logic r);
      exp_t got;
      drive(s, st, fl, r);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         got = exp_q.pop_front();
         check({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, got.we});
         if (got.chk_rf) begin
            check({tag, " rf_wr_reg"}, {27'd0, rf_wr_reg}, {27'd0, got.wreg});
            check({tag, " rf_wr_data"}, rf_wr_data, got.data);
         end
         check({tag, " id_rd1"}, id_rd1, got.rd1);
         check({tag, " id_rd2"}, id_rd2, got.rd2);
         check({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, got.valid});
      end
   endtask

   stim_t sa, sb;
   exp_t  ea, ez;

   initial begin
      // valid, rw, wb_sel, lt, off, dest, alu, mem, link, rs, rt, raw1, raw2
      vecs[0]  = '{stim_t'{1, 1, 2'd0, 3'd0, 2'd0, 5'd5,  32'h12345678, MD, LP, 5'd5,  5'd6,  32'hAAAA0000, 32'hBBBB0000},
                   exp_t'{1, 5'd5,  32'h12345678, 32'h12345678, 32'hBBBB0000, 1, 1}};
      vecs[1]  = '{stim_t'{1, 1, 2'd1, 3'd3, 2'd0, 5'd8,  32'h11111111, MD, LP, 5'd7,  5'd8,  32'h00000001, 32'h00000002},
                   exp_t'{1, 5'd8,  32'hFFFFFF80, 32'h00000001, 32'hFFFFFF80, 1, 1}};
      vecs[2]  = '{stim_t'{1, 1, 2'd1, 3'd4, 2'd3, 5'd8,  32'h11111111, MD, LP, 5'd8,  5'd8,  32'h00000001, 32'h00000002},
                   exp_t'{1, 5'd8,  32'h0000007F, 32'h0000007F, 32'h0000007F, 1, 1}};
      vecs[3]  = '{stim_t'{1, 1, 2'd1, 3'd1, 2'd2, 5'd12, 32'h11111111, MD, LP, 5'd1,  5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd12, 32'hFFFFA27F, 32'h00000003, 32'h00000004, 1, 1}};
      vecs[4]  = '{stim_t'{1, 1, 2'd1, 3'd2, 2'd0, 5'd12, 32'h11111111, MD, LP, 5'd12, 5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd12, 32'h000080F1, 32'h000080F1, 32'h00000004, 1, 1}};
      vecs[5]  = '{stim_t'{1, 1, 2'd1, 3'd0, 2'd1, 5'd13, 32'h11111111, MD, LP, 5'd1,  5'd13, 32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd13, 32'h80F1A27F, 32'h00000003, 32'h80F1A27F, 1, 1}};
      vecs[6]  = '{stim_t'{1, 1, 2'd1, 3'd3, 2'd1, 5'd14, 32'h11111111, MD, LP, 5'd1,  5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd14, 32'hFFFFFFF1, 32'h00000003, 32'h00000004, 1, 1}};
      vecs[7]  = '{stim_t'{1, 1, 2'd1, 3'd4, 2'd2, 5'd14, 32'h11111111, MD, LP, 5'd1,  5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd14, 32'h000000A2, 32'h00000003, 32'h00000004, 1, 1}};
      vecs[8]  = '{stim_t'{1, 1, 2'd1, 3'd1, 2'd1, 5'd14, 32'h11111111, MD, LP, 5'd1,  5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd14, 32'hFFFF80F1, 32'h00000003, 32'h00000004, 1, 1}};
      vecs[9]  = '{stim_t'{1, 1, 2'd1, 3'd2, 2'd3, 5'd14, 32'h11111111, MD, LP, 5'd1,  5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd14, 32'h0000A27F, 32'h00000003, 32'h00000004, 1, 1}};
      vecs[10] = '{stim_t'{1, 1, 2'd1, 3'd5, 2'd2, 5'd14, 32'h11111111, MD, LP, 5'd1,  5'd2,  32'h00000003, 32'h00000004},
                   exp_t'{1, 5'd14, 32'h80F1A27F, 32'h00000003, 32'h00000004, 1, 1}};
      vecs[11] = '{stim_t'{1, 1, 2'd0, 3'd0, 2'd0, 5'd0,  32'hDEADBEEF, MD, LP, 5'd0,  5'd0,  32'hCAFE0000, 32'h0BEEF000},
                   exp_t'{0, 5'd0,  32'hDEADBEEF, 32'hCAFE0000, 32'h0BEEF000, 1, 1}};
      vecs[12] = '{stim_t'{1, 1, 2'd2, 3'd0, 2'd0, 5'd31, 32'h99999999, MD, LP, 5'd31, 5'd2,  32'h00000005, 32'h00000006},
                   exp_t'{1, 5'd31, 32'h00400008, 32'h00400008, 32'h00000006, 1, 1}};
      vecs[13] = '{stim_t'{1, 1, 2'd3, 3'd0, 2'd0, 5'd4,  32'h13572468, MD, LP, 5'd1,  5'd4,  32'h00000005, 32'h00000006},
                   exp_t'{1, 5'd4,  32'h13572468, 32'h00000005, 32'h13572468, 1, 1}};
      vecs[14] = '{stim_t'{1, 0, 2'd0, 3'd0, 2'd0, 5'd5,  32'h24682468, MD, LP, 5'd5,  5'd5,  32'h00000007, 32'h00000008},
                   exp_t'{0, 5'd5,  32'h24682468, 32'h00000007, 32'h00000008, 1, 1}};
      vecs[15] = '{stim_t'{0, 1, 2'd0, 3'd0, 2'd0, 5'd5,  32'h36923692, MD, LP, 5'd5,  5'd5,  32'h00000007, 32'h00000008},
                   exp_t'{0, 5'd5,  32'h36923692, 32'h00000007, 32'h00000008, 0, 1}};
      vecs[16] = '{stim_t'{1, 1, 2'd0, 3'd0, 2'd0, 5'd5,  32'h48124812, MD, LP, 5'd4,  5'd6,  32'h00000007, 32'h00000008},
                   exp_t'{1, 5'd5,  32'h48124812, 32'h00000007, 32'h00000008, 1, 1}};

      // Reset held while a valid writing instruction is presented.
      sa = '{1, 1, 2'd0, 3'd0, 2'd0, 5'd5, 32'h12345678, MD, LP, 5'd5, 5'd6, 32'h00000055, 32'h00000066};
      ez = '{0, 5'd0, 32'h00000000, 32'h00000055, 32'h00000066, 0, 1};
      drive(sa, 1'b0, 1'b0, 1'b0);
      #1;
      cycle("reset0", sa, ez, 1'b0, 1'b0, 1'b0);
      cycle("reset1", sa, ez, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < NV; i++) begin
         cycle($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, 1'b0, 1'b0, 1'b1);
      end

      // Stall for three cycles with different inputs, then stall+flush.
      sa = '{1, 1, 2'd0, 3'd0, 2'd0, 5'd9,  32'h0BADF00D, MD, LP, 5'd9, 5'd3, 32'h00000001, 32'h00000002};
      sb = '{1, 1, 2'd2, 3'd0, 2'd0, 5'd10, 32'h77777777, MD, LP, 5'd9, 5'd3, 32'h00000001, 32'h00000002};
      ea = '{1, 5'd9, 32'h0BADF00D, 32'h0BADF00D, 32'h00000002, 1, 1};
      cycle("stall_load", sa, ea, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle($sformatf("stall%0d", i), sb, ea, 1'b1, 1'b0, 1'b1);
      end
      cycle("stall_flush", sb, exp_t'{0, 5'd0, 32'd0, 32'h00000001, 32'h00000002, 0, 0},
            1'b1, 1'b1, 1'b1);
      cycle("after_flush", sb, exp_t'{1, 5'd10, 32'h00400008, 32'h00000001, 32'h00000002, 1, 1},
            1'b0, 1'b0, 1'b1);

      // Reset during a stall clears the stage; nothing is written afterwards.
      cycle("rst_stall_load", sa, ea, 1'b0, 1'b0, 1'b1);
      cycle("rst_stall", sb, exp_t'{0, 5'd0, 32'd0, 32'h00000001, 32'h00000002, 0, 1},
            1'b1, 1'b0, 1'b0);
      cycle("rst_stall_after", sb, exp_t'{0, 5'd0, 32'd0, 32'h00000001, 32'h00000002, 0, 1},
            1'b1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
